// File: rtl/nibble_serializer_pkg.sv
// Shared types and constants for the nibble serializer.
// The checksum state is only used when NIBBLE_SER_CHKSUM_EN is defined.
package nibble_serializer_pkg;

  localparam int NIB_W  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHK   = 2'd2
  } state_e;

  // Lengths above the nibble capacity saturate; zero stays zero (word discarded).
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_nib);
    return (len > max_nib) ? max_nib : len;
  endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// Word-in / nibble-out bus of the nibble serializer.
// slave is the serializer's view, master is the upstream/downstream side.
interface nibble_serializer_if #(
  parameter int CNT_W = 16
) ();

  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_data_i;
  logic [3:0]       in_len_i;
  logic             fifo_full_i;
  logic             fifo_wr_valid_o;
  logic [3:0]       fifo_wr_data_o;
  logic             busy_o;
  logic [CNT_W-1:0] word_count_o;

  modport slave (
    input  in_valid_i, in_data_i, in_len_i, fifo_full_i,
    output in_ready_o, fifo_wr_valid_o, fifo_wr_data_o, busy_o, word_count_o
  );

  modport master (
    output in_valid_i, in_data_i, in_len_i, fifo_full_i,
    input  in_ready_o, fifo_wr_valid_o, fifo_wr_data_o, busy_o, word_count_o
  );

endinterface

// File: rtl/nibble_serializer.sv
// Serializes a 32-bit word into up to MAX_NIB nibbles, LSB nibble first, into a nibble FIFO.
// Defining NIBBLE_SER_CHKSUM_EN appends an XOR checksum nibble after each word's payload.
module nibble_serializer
  import nibble_serializer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MAX_NIB = 8
) (
  input  logic               wclock,
  input  logic               reset,
  nibble_serializer_if.slave bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [3:0]        rem_q, rem_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        len_clamped;
  logic              wr_valid;
  logic [NIB_W-1:0]  wr_data;
`ifdef NIBBLE_SER_CHKSUM_EN
  logic [NIB_W-1:0]  chk_q, chk_d;
`endif

  assign len_clamped = clamp_len(bus.in_len_i, 4'(MAX_NIB));

  always_ff @(posedge wclock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      count_q <= '0;
`ifdef NIBBLE_SER_CHKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      count_q <= count_d;
`ifdef NIBBLE_SER_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    rem_d    = rem_q;
    count_d  = count_q;
    wr_valid = 1'b0;
    wr_data  = '0;
`ifdef NIBBLE_SER_CHKSUM_EN
    chk_d    = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A zero-length word is consumed here without ever leaving IDLE.
        if (bus.in_valid_i && (len_clamped != 4'd0)) begin
          shreg_d = bus.in_data_i;
          rem_d   = len_clamped;
          state_d = ST_SHIFT;
`ifdef NIBBLE_SER_CHKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      ST_SHIFT: begin
        wr_valid = !bus.fifo_full_i;
        wr_data  = shreg_q[NIB_W-1:0];
        if (wr_valid) begin
          shreg_d = shreg_q >> NIB_W;
          rem_d   = rem_q - 4'd1;
`ifdef NIBBLE_SER_CHKSUM_EN
          chk_d   = chk_q ^ wr_data;
          if (rem_q == 4'd1) state_d = ST_CHK;
`else
          if (rem_q == 4'd1) begin
            state_d = ST_IDLE;
            count_d = count_q + 1'b1;
          end
`endif
        end
      end
`ifdef NIBBLE_SER_CHKSUM_EN
      ST_CHK: begin
        // The checksum nibble completes the word, so it is what gets counted.
        wr_valid = !bus.fifo_full_i;
        wr_data  = chk_q;
        if (wr_valid) begin
          state_d = ST_IDLE;
          count_d = count_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating ready with reset keeps it low while reset is held.
  assign bus.in_ready_o      = reset && (state_q == ST_IDLE);
  assign bus.busy_o          = (state_q != ST_IDLE);
  assign bus.fifo_wr_valid_o = wr_valid;
  assign bus.fifo_wr_data_o  = wr_data;
  assign bus.word_count_o    = count_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer: directed cases plus randomized words and stalls,
// scored against a nibble-queue model; a second narrow-counter instance exercises count wrap.
module tb_nibble_serializer;

  logic        wclock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_len;
  logic        fifo_full;
  logic        manual_en, rand_en, full_man, full_rand;

  nibble_serializer_if #(.CNT_W(16)) bus ();
  nibble_serializer_if #(.CNT_W(3))  bus_w ();

  nibble_serializer #(.CNT_W(16), .MAX_NIB(8)) dut (
    .wclock (wclock),
    .reset  (reset),
    .bus    (bus)
  );

  nibble_serializer #(.CNT_W(3), .MAX_NIB(8)) dut_w (
    .wclock (wclock),
    .reset  (reset),
    .bus    (bus_w)
  );

  assign fifo_full = manual_en ? full_man : (rand_en ? full_rand : 1'b0);

  assign bus.in_valid_i    = in_valid;
  assign bus.in_data_i     = in_data;
  assign bus.in_len_i      = in_len;
  assign bus.fifo_full_i   = fifo_full;
  assign bus_w.in_valid_i  = in_valid;
  assign bus_w.in_data_i   = in_data;
  assign bus_w.in_len_i    = in_len;
  assign bus_w.fifo_full_i = fifo_full;

  initial wclock = 1'b0;
  always #5 wclock = ~wclock;

  always @(posedge wclock) begin
    #1 full_rand = ($urandom_range(0, 3) == 0);
  end

  int          checks = 0;
  int          errors = 0;
  int          n_writes = 0;
  logic [31:0] model_count = 0;
  logic [3:0]  last_wr = 4'h0;
  logic [4:0]  exp_q[$];    // {last nibble of word, nibble}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model of an accepted word: the nibble sequence it must produce.
  task automatic model_accept(input logic [31:0] d, input logic [3:0] l);
    int         n;
    logic [3:0] x;
    n = (l > 4'd8) ? 8 : int'(l);
    x = 4'h0;
    for (int i = 0; i < n; i++) begin
      x = x ^ d[4*i +: 4];
`ifdef NIBBLE_SER_CHKSUM_EN
      exp_q.push_back({1'b0, d[4*i +: 4]});
`else
      exp_q.push_back({(i == n - 1), d[4*i +: 4]});
`endif
    end
`ifdef NIBBLE_SER_CHKSUM_EN
    if (n > 0) exp_q.push_back({1'b1, x});
`endif
  endtask

  always @(negedge wclock) begin
    logic       exp_busy;
    logic [4:0] e;
    if (!reset) begin
      check_eq("rst_ready", bus.in_ready_o, 0);
      check_eq("rst_busy", bus.busy_o, 0);
      check_eq("rst_wr_valid", bus.fifo_wr_valid_o, 0);
      check_eq("rst_wr_data", bus.fifo_wr_data_o, 0);
      check_eq("rst_count", bus.word_count_o, 0);
      check_eq("rst_count_w", bus_w.word_count_o, 0);
      exp_q.delete();
      model_count = 0;
    end else begin
      exp_busy = (exp_q.size() != 0);
      check_eq("busy", bus.busy_o, exp_busy);
      check_eq("ready", bus.in_ready_o, !exp_busy);
      check_eq("wr_valid", bus.fifo_wr_valid_o, exp_busy && !fifo_full);
      check_eq("count", bus.word_count_o, model_count[15:0]);
      check_eq("count_w", bus_w.word_count_o, model_count[2:0]);
      if (!exp_busy) check_eq("idle_wr_data", bus.fifo_wr_data_o, 0);
      if (bus.fifo_wr_valid_o) begin
        n_writes++;
        last_wr = bus.fifo_wr_data_o;
        check_eq("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("nibble", bus.fifo_wr_data_o, e[3:0]);
          if (e[4]) model_count++;
        end
      end
      if (in_valid && !exp_busy) model_accept(in_data, in_len);
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] l);
    int n;
    n = 0;
    in_data  = d;
    in_len   = l;
    in_valid = 1'b1;
    forever begin
      @(negedge wclock);
      if (bus.in_ready_o) break;
      n++;
      if (n > 500) begin
        check_eq("accept_bound", bus.in_ready_o, 1);
        break;
      end
    end
    @(posedge wclock);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_len   = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge wclock);
      n++;
    end while (exp_q.size() != 0 && n < 500);
    if (n >= 500) check_eq("idle_bound", exp_q.size(), 0);
    @(posedge wclock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, w0;
    logic [31:0] c0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    manual_en = 1'b0;
    rand_en   = 1'b0;
    full_man  = 1'b0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    #2;
    check_eq("por_ready", bus.in_ready_o, 0);
    check_eq("por_count", bus.word_count_o, 0);
    repeat (3) @(posedge wclock);
    #1 reset = 1'b1;
    @(posedge wclock); #1;

    // Full-length word, no stalls: latency and first-nibble timing.
    send_word(32'h8765_4321, 4'd8);
    k = 0;
    forever begin
      @(negedge wclock);
      k++;
      if (k == 1) begin
        check_eq("first_valid", bus.fifo_wr_valid_o, 1);
        check_eq("first_nibble", bus.fifo_wr_data_o, 4'h1);
      end
      if (bus.in_ready_o || k > 40) break;
    end
`ifdef NIBBLE_SER_CHKSUM_EN
    check_eq("ready_latency", k, 10);
`else
    check_eq("ready_latency", k, 9);
`endif
    @(posedge wclock); #1;
    check_eq("count_after_first", bus.word_count_o, 1);

    // Stall for two cycles after the first nibble.
    manual_en = 1'b1;
    w0 = n_writes;
    send_word(32'h0000_ABCD, 4'd3);
    @(negedge wclock);
    check_eq("stall_first", bus.fifo_wr_data_o, 4'hD);
    @(posedge wclock); #1 full_man = 1'b1;
    @(negedge wclock);
    check_eq("stall_hold1", bus.fifo_wr_valid_o, 0);
    @(posedge wclock); #1;
    @(negedge wclock);
    check_eq("stall_hold2", bus.fifo_wr_valid_o, 0);
    @(posedge wclock); #1 full_man = 1'b0;
    @(negedge wclock);
    check_eq("stall_resume", bus.fifo_wr_data_o, 4'hC);
    @(posedge wclock); #1;
    wait_idle();
`ifdef NIBBLE_SER_CHKSUM_EN
    check_eq("stall_writes", n_writes - w0, 4);
`else
    check_eq("stall_writes", n_writes - w0, 3);
`endif
    manual_en = 1'b0;

    // Zero length is discarded; length 12 clamps to 8.
    c0 = model_count;
    w0 = n_writes;
    send_word(32'hFFFF_FFFF, 4'd0);
    @(posedge wclock); #1;
    check_eq("len0_writes", n_writes - w0, 0);
    check_eq("len0_count", bus.word_count_o, c0[15:0]);
    send_word(32'hFFFF_FFFF, 4'd12);
    wait_idle();
`ifdef NIBBLE_SER_CHKSUM_EN
    check_eq("len12_writes", n_writes - w0, 9);
`else
    check_eq("len12_writes", n_writes - w0, 8);
`endif
    check_eq("len12_count", bus.word_count_o, 16'(c0 + 1));

`ifdef NIBBLE_SER_CHKSUM_EN
    send_word(32'h0000_0321, 4'd3);
    wait_idle();
    check_eq("chk_nibble", last_wr, 4'h0);
`endif

    // Randomized words, lengths, gaps and FIFO stalls.
    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge wclock);
      #1;
      send_word($urandom, 4'($urandom));
    end
    wait_idle();
    rand_en = 1'b0;

    // Reset in the middle of a 6-nibble word.
    send_word(32'h00AB_CDEF, 4'd6);
    @(negedge wclock);
    @(negedge wclock);
    @(posedge wclock);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_wr_valid", bus.fifo_wr_valid_o, 0);
    check_eq("midrst_wr_data", bus.fifo_wr_data_o, 0);
    check_eq("midrst_busy", bus.busy_o, 0);
    check_eq("midrst_count", bus.word_count_o, 0);
    repeat (2) @(negedge wclock);
    @(posedge wclock);
    #3 reset = 1'b1;
    @(negedge wclock);
    check_eq("postrst_ready", bus.in_ready_o, 1);
    check_eq("postrst_count", bus.word_count_o, 0);
    @(posedge wclock); #1;

    send_word(32'h0000_0005, 4'd1);
    wait_idle();
    check_eq("postrst_word", bus.word_count_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
